// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_pkg
// Purpose  : Shared constants for the inter-stage pipeline registers: reset
//            level, NOP record field values and default field widths.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    localparam int          RegBus       = 32;
    localparam int          RegAddrBus   = 5;
    localparam int          InstTypeBus  = 6;

    localparam logic [RegBus-1:0]      ZeroWord    = '0;
    localparam logic [RegAddrBus-1:0]  NOPRegAdder = 5'b00000;
    localparam logic [InstTypeBus-1:0] NOPInstType = 6'b000000;

    // Number of valid entries from the two entry valid bits.
    function automatic logic [1:0] occ_count(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_entry.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_entry
// Purpose  : One valid-tagged payload register (the pipe entry) with load and
//            clear. Clear wins over load; the payload is left untouched on
//            clear because consumers always qualify it with the valid bit.
// Ports    : clk_in, rst_in (async, active-high)
//            load_in   - capture d_in and mark valid
//            clear_in  - mark invalid
//            d_in      - payload in (W bits)
//            valid_out - entry holds a record
//            q_out     - held payload
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         load_in,
    input  logic         clear_in,
    input  logic [W-1:0] d_in,
    output logic         valid_out,
    output logic [W-1:0] q_out
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == RstEnable) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (clear_in) begin
            r_valid <= 1'b0;
        end else if (load_in) begin
            r_valid <= 1'b1;
            r_data  <= d_in;
        end
    end

    assign valid_out = r_valid;
    assign q_out     = r_data;

endmodule : pipe_stage_reg_entry
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Elastic pipeline-stage register for one writeback record
//            (we, value, dest addr, inst type) with ready/valid handshakes,
//            flush and NOP bubble output.
//            Build option PIPE_STAGE_SKID_EN: two entries (MAIN + SKID),
//            registered up_ready_out. Without it: single entry with
//            combinational up_ready_out.
// Ports    : clk_in, rst_in (async, active-high), rdy_in (run enable),
//            flush_in, up_valid_in/up_ready_out + rd_*_in/inst_type_in
//            (upstream), dn_valid_out/dn_ready_in + rd_*_out/inst_type_out
//            (downstream), occupancy_out (entries held).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus,
    parameter int TYPE_W = InstTypeBus
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              up_valid_in,
    output logic              up_ready_out,
    input  logic              rd_we_in,
    input  logic [DATA_W-1:0] rd_val_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic [TYPE_W-1:0] inst_type_in,
    output logic              dn_valid_out,
    input  logic              dn_ready_in,
    output logic              rd_we_out,
    output logic [DATA_W-1:0] rd_val_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [TYPE_W-1:0] inst_type_out,
    output logic [1:0]        occupancy_out
);

    localparam int                c_pw       = 1 + DATA_W + ADDR_W + TYPE_W;
    localparam logic [DATA_W-1:0] c_nop_val  = DATA_W'(ZeroWord);
    localparam logic [ADDR_W-1:0] c_nop_addr = ADDR_W'(NOPRegAdder);
    localparam logic [TYPE_W-1:0] c_nop_type = TYPE_W'(NOPInstType);

    logic [c_pw-1:0]   w_up_pack;
    logic              w_up_ready;
    logic              w_up_fire;
    logic              w_dn_fire;

    logic              w_main_valid;
    logic              w_main_load;
    logic              w_main_clear;
    logic [c_pw-1:0]   w_main_d;
    logic [c_pw-1:0]   w_main_q;

    logic              w_main_we;
    logic [DATA_W-1:0] w_main_val;
    logic [ADDR_W-1:0] w_main_addr;
    logic [TYPE_W-1:0] w_main_type;

    assign w_up_pack = {rd_we_in, rd_val_in, rd_addr_in, inst_type_in};
    assign w_up_fire = up_valid_in & w_up_ready & rdy_in;
    assign w_dn_fire = w_main_valid & dn_ready_in & rdy_in;

    pipe_stage_reg_entry #(.W(c_pw)) u_main (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_in   (w_main_load),
        .clear_in  (w_main_clear),
        .d_in      (w_main_d),
        .valid_out (w_main_valid),
        .q_out     (w_main_q)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic            w_skid_valid;
    logic            w_skid_load;
    logic            w_skid_clear;
    logic [c_pw-1:0] w_skid_q;

    // Ready depends only on the SKID valid flop, so there is no
    // combinational path from dn_ready_in to up_ready_out.
    assign w_up_ready = ~w_skid_valid;

    // MAIN refills from SKID when SKID is occupied (oldest first), otherwise
    // from the input when MAIN is empty or draining this cycle.
    assign w_main_load  = (w_up_fire & (~w_main_valid | (w_dn_fire & ~w_skid_valid)))
                        | (w_dn_fire & w_skid_valid);
    assign w_main_d     = w_skid_valid ? w_skid_q : w_up_pack;
    assign w_main_clear = flush_in | (w_dn_fire & ~w_skid_valid & ~w_up_fire);

    // SKID catches the input only when MAIN is stalled.
    assign w_skid_load  = w_up_fire & w_main_valid & ~w_dn_fire;
    assign w_skid_clear = flush_in | (w_dn_fire & w_skid_valid);

    pipe_stage_reg_entry #(.W(c_pw)) u_skid (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_in   (w_skid_load),
        .clear_in  (w_skid_clear),
        .d_in      (w_up_pack),
        .valid_out (w_skid_valid),
        .q_out     (w_skid_q)
    );

    assign occupancy_out = occ_count(w_main_valid, w_skid_valid);
`else
    // Single entry: a full stage still accepts when it drains this cycle.
    assign w_up_ready    = ~w_main_valid | (dn_ready_in & rdy_in);

    assign w_main_load   = w_up_fire;
    assign w_main_d      = w_up_pack;
    assign w_main_clear  = flush_in | (w_dn_fire & ~w_up_fire);

    assign occupancy_out = occ_count(w_main_valid, 1'b0);
`endif

    assign up_ready_out = w_up_ready;

    assign {w_main_we, w_main_val, w_main_addr, w_main_type} = w_main_q;

    // Bubbles are presented as NOP records so downstream never sees stale data.
    assign dn_valid_out  = w_main_valid;
    assign rd_we_out     = w_main_valid ? w_main_we   : WriteDisable;
    assign rd_val_out    = w_main_valid ? w_main_val  : c_nop_val;
    assign rd_addr_out   = w_main_valid ? w_main_addr : c_nop_addr;
    assign inst_type_out = w_main_valid ? w_main_type : c_nop_type;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg. Exercises both
//            build flavours depending on PIPE_STAGE_SKID_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        up_valid_in;
    logic        up_ready_out;
    logic        rd_we_in;
    logic [31:0] rd_val_in;
    logic [4:0]  rd_addr_in;
    logic [5:0]  inst_type_in;
    logic        dn_valid_out;
    logic        dn_ready_in;
    logic        rd_we_out;
    logic [31:0] rd_val_out;
    logic [4:0]  rd_addr_out;
    logic [5:0]  inst_type_out;
    logic [1:0]  occupancy_out;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    pipe_stage_reg u_dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .up_valid_in   (up_valid_in),
        .up_ready_out  (up_ready_out),
        .rd_we_in      (rd_we_in),
        .rd_val_in     (rd_val_in),
        .rd_addr_in    (rd_addr_in),
        .inst_type_in  (inst_type_in),
        .dn_valid_out  (dn_valid_out),
        .dn_ready_in   (dn_ready_in),
        .rd_we_out     (rd_we_out),
        .rd_val_out    (rd_val_out),
        .rd_addr_out   (rd_addr_out),
        .inst_type_out (inst_type_out),
        .occupancy_out (occupancy_out)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic [31:0] v);
        up_valid_in = 1'b1;
        rd_val_in   = v;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_dnv"},  64'(dn_valid_out),  64'd0);
        chk({tag, "_val"},  64'(rd_val_out),    64'd0);
        chk({tag, "_we"},   64'(rd_we_out),     64'd0);
        chk({tag, "_addr"}, 64'(rd_addr_out),   64'd0);
        chk({tag, "_type"}, 64'(inst_type_out), 64'd0);
    endtask

    initial begin
        rst_in       = 1'b1;
        rdy_in       = 1'b1;
        flush_in     = 1'b0;
        up_valid_in  = 1'b0;
        dn_ready_in  = 1'b0;
        rd_we_in     = 1'b1;
        rd_val_in    = '0;
        rd_addr_in   = 5'd9;
        inst_type_in = 6'd17;

        // Reset state before any clock edge
        #3;
        chk_bubble("rst");
        chk("rst_upr", 64'(up_ready_out),  64'd1);
        chk("rst_occ", 64'(occupancy_out), 64'd0);
        tick();
        tick();
        rst_in = 1'b0;

        // Stream 1..4, one per cycle, one-cycle latency
        dn_ready_in = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            offer(32'(v));
            tick();
            chk("strm_dnv", 64'(dn_valid_out), 64'd1);
            chk("strm_val", 64'(rd_val_out),   64'(v));
        end
        chk("strm_addr", 64'(rd_addr_out),   64'd9);
        chk("strm_type", 64'(inst_type_out), 64'd17);
        chk("strm_we",   64'(rd_we_out),     64'd1);
        up_valid_in = 1'b0;
        tick();
        chk_bubble("strm_end");

`ifdef PIPE_STAGE_SKID_EN
        // Fill both entries with downstream stalled
        dn_ready_in = 1'b0;
        offer(32'hA);
        tick();
        chk("sk_occ1", 64'(occupancy_out), 64'd1);
        chk("sk_upr1", 64'(up_ready_out),  64'd1);
        offer(32'hB);
        tick();
        chk("sk_occ2", 64'(occupancy_out), 64'd2);
        chk("sk_upr2", 64'(up_ready_out),  64'd0);
        chk("sk_valA", 64'(rd_val_out),    64'hA);
        up_valid_in = 1'b0;
        tick();
        chk("sk_hold", 64'(rd_val_out),    64'hA);
        dn_ready_in = 1'b1;
        tick();
        chk("sk_valB", 64'(rd_val_out),    64'hB);
        chk("sk_occ3", 64'(occupancy_out), 64'd1);
        chk("sk_upr3", 64'(up_ready_out),  64'd1);
        tick();
        chk("sk_drain", 64'(dn_valid_out),  64'd0);
        chk("sk_occ0",  64'(occupancy_out), 64'd0);

        // Flush with both entries held and a pending upstream record
        dn_ready_in = 1'b0;
        offer(32'h11);
        tick();
        offer(32'h12);
        tick();
        chk("skf_occ2", 64'(occupancy_out), 64'd2);
        offer(32'hC);
        flush_in = 1'b1;
        tick();
        flush_in    = 1'b0;
        up_valid_in = 1'b0;
        chk("skf_occ", 64'(occupancy_out), 64'd0);
        chk("skf_dnv", 64'(dn_valid_out),  64'd0);
        chk("skf_upr", 64'(up_ready_out),  64'd1);
        dn_ready_in = 1'b1;
        tick();
        chk("skf_noC", 64'(dn_valid_out),  64'd0);
`else
        // Full single entry accepts combinationally when downstream drains
        dn_ready_in = 1'b0;
        offer(32'h31);
        tick();
        chk("ns_val1", 64'(rd_val_out),    64'h31);
        chk("ns_occ1", 64'(occupancy_out), 64'd1);
        offer(32'h32);
        #1;
        chk("ns_upr0", 64'(up_ready_out),  64'd0);
        dn_ready_in = 1'b1;
        #1;
        chk("ns_upr1", 64'(up_ready_out),  64'd1);
        tick();
        chk("ns_dnv2", 64'(dn_valid_out),  64'd1);
        chk("ns_val2", 64'(rd_val_out),    64'h32);
        up_valid_in = 1'b0;
        tick();
        chk("ns_drain", 64'(dn_valid_out), 64'd0);

        // Flush discards a record that would otherwise be accepted
        dn_ready_in = 1'b0;
        offer(32'h11);
        tick();
        dn_ready_in = 1'b1;
        offer(32'hC);
        flush_in = 1'b1;
        tick();
        flush_in    = 1'b0;
        up_valid_in = 1'b0;
        chk("nsf_occ", 64'(occupancy_out), 64'd0);
        chk("nsf_dnv", 64'(dn_valid_out),  64'd0);
        tick();
        chk("nsf_noC", 64'(dn_valid_out),  64'd0);
`endif

        // Freeze with traffic on both sides, then resume in order
        dn_ready_in = 1'b0;
        offer(32'h55);
        tick();
        offer(32'h66);
        rdy_in      = 1'b0;
        dn_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_dnv", 64'(dn_valid_out),  64'd1);
            chk("frz_val", 64'(rd_val_out),    64'h55);
            chk("frz_occ", 64'(occupancy_out), 64'd1);
`ifndef PIPE_STAGE_SKID_EN
            chk("frz_upr", 64'(up_ready_out),  64'd0);
`endif
        end
        rdy_in = 1'b1;
        tick();
        chk("frz_res", 64'(rd_val_out), 64'h66);
        up_valid_in = 1'b0;
        tick();
        chk("frz_end", 64'(dn_valid_out), 64'd0);

        // Flush overrides a frozen stage
        dn_ready_in = 1'b0;
        offer(32'h88);
        tick();
        up_valid_in = 1'b0;
        rdy_in      = 1'b0;
        flush_in    = 1'b1;
        tick();
        flush_in = 1'b0;
        rdy_in   = 1'b1;
        chk("fz_fl_dnv", 64'(dn_valid_out),  64'd0);
        chk("fz_fl_occ", 64'(occupancy_out), 64'd0);

        // Asynchronous reset mid-transfer
        offer(32'h99);
        tick();
        chk("ar_pre", 64'(rd_val_out), 64'h99);
        offer(32'h9A);
        #2;
        rst_in = 1'b1;
        #1;
        chk_bubble("ar");
        chk("ar_upr", 64'(up_ready_out),  64'd1);
        chk("ar_occ", 64'(occupancy_out), 64'd0);
        tick();
        rst_in      = 1'b0;
        up_valid_in = 1'b0;
        tick();
        chk("ar_post_dnv", 64'(dn_valid_out),  64'd0);
        chk("ar_post_occ", 64'(occupancy_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
